// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder: a request is accepted in IDLE, the
// access commits LATENCY cycles later, and the response is held until taken.
module dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic [3:0]  wmask_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        commit;

    logic [31:0] mem [DEPTH_WORDS];

    // Commit-side view of the request: live inputs when LATENCY==1 commits on
    // the accept edge itself, otherwise the copy captured at accept.
    logic [31:0] c_addr, c_wdata;
    logic        c_wen, c_err;
    logic [3:0]  c_wmask;
    logic [AW-1:0] c_idx;

    always_comb begin
        if (state_q == S_IDLE) begin
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wen   = req_wen;
            c_wmask = req_wmask;
        end else begin
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_wen   = wen_q;
            c_wmask = wmask_q;
        end
        c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= DEPTH_WORDS);
        c_idx = c_addr[2 +: AW];
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            wmask_q <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wen_q   <= req_wen;
                wmask_q <= req_wmask;
            end
            if (commit) begin
                err_q   <= c_err;
                rdata_q <= (!c_wen && !c_err) ? mem[c_idx] : 32'd0;
            end
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Byte-lane store; reset on the commit edge wins and suppresses the write.
    // NOTE: storage is deliberately not reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_wen && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wmask[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words of backing storage, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wen  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_wmask  input  4  byte-lane write enables; bit i selects byte i, [7+8i:8i].
REQ-010 SHALL have port req_wdata  input  32  store data.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and for errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement three states: IDLE, WAIT, RESP; at most one request outstanding.
REQ-016 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 SHALL accept a request when req_valid && req_ready; it SHALL capture addr, wen, wmask and wdata on that edge.
REQ-018 After accept, if LATENCY==1 the block SHALL go to RESP; otherwise it SHALL go to WAIT with a down-counter loaded with LATENCY-1.
REQ-019 In WAIT the counter SHALL decrement each cycle; on the edge where it reaches 0 the block SHALL go to RESP.
REQ-020 Timing: accept edge at end of cycle T means rsp_valid=1 first in cycle T+LATENCY.
REQ-021 On the edge entering RESP the block SHALL perform the access (commit edge): a store writes the selected lanes, a load latches the word into rsp_rdata.
REQ-022 In RESP, rsp_rdata and rsp_err SHALL stay stable until rsp_valid && rsp_ready; on that edge the block SHALL return to IDLE.
REQ-023 req_ready SHALL be 1 in the cycle after the response handshake; there is no same-cycle response/accept overlap.
REQ-024 Error: req_addr[1:0]!=0, or word index >= DEPTH_WORDS (req_addr[31:2]), SHALL give rsp_err=1 and rsp_rdata=0, with no storage modification.
REQ-025 A store with req_wmask=0 SHALL complete with rsp_err=0 and storage unchanged.
REQ-026 Loads SHALL ignore req_wmask and return the full word.
REQ-027 A load issued after a completed store to the same word SHALL return the updated bytes.
REQ-028 req_* inputs SHALL be ignored outside IDLE; changes during WAIT/RESP SHALL have no effect.
REQ-029 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-030 On any edge with rst=1, state SHALL become IDLE, the counter 0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset in WAIT SHALL discard the request; a pending store SHALL NOT be written.
REQ-032 Reset on the same edge as a commit SHALL take priority, so no write occurs.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-034 Scenario: LATENCY=2; store addr 0x10, wdata 0xDEADBEEF, wmask 0xF; then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
REQ-035 Scenario: word 0x10 = 0xDEADBEEF; store wdata 0x00000055, wmask 0x1; load 0x10 -> 0xDEADBE55.
REQ-036 Scenario: load 0x12 -> rsp_err=1, rsp_rdata=0; load 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1; storage unchanged.
REQ-037 Scenario: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; after handshake, req_ready=1 next cycle.
REQ-038 Scenario: store 0xCAFEF00D to 0x20 with rst=1 during WAIT -> rsp_valid never asserts and a subsequent load of 0x20 returns the prior value.
REQ-039 Scenario: LATENCY=1, back-to-back requests with rsp_ready tied 1 -> one accept every 2 cycles, responses in order.
